// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - j1 I/O-bus UART: 8N1 TX/RX with programmable divisor
// Build option UART_RX_FIFO_EN: RX_DEPTH-entry RX FIFO instead of a single holding byte.
module j1_uart_io #(
  parameter logic [15:0] BASE_ADDR   = 16'h6000,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          RX_DEPTH    = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_dout_i,
  output logic [15:0] io_din_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        rx_irq_o
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic       sel;
  logic [1:0] idx;
  logic       wr_data, wr_stat, wr_div, rd_pop;

  assign sel     = (io_addr_i[15:3] == BASE_ADDR[15:3]);
  assign idx     = io_addr_i[2:1];
  assign wr_data = sel && io_wr_i && (idx == 2'd0);
  assign wr_stat = sel && io_wr_i && (idx == 2'd1);
  assign wr_div  = sel && io_wr_i && (idx == 2'd2);

  logic unused_addr;
  assign unused_addr = io_addr_i[0];

  logic [15:0] divisor;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      divisor <= DEFAULT_DIV;
    end else if (wr_div) begin
      divisor <= (io_dout_i < 16'd4) ? 16'd4 : io_dout_i;
    end
  end

  // Transmitter. Each state latches the divisor at its start so a divisor
  // write only affects the next bit.
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_bit_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift, tx_hold;
  logic        tx_full, tx_line, tx_tick, tx_busy;

  assign tx_tick   = (tx_cnt == tx_bit_div - 16'd1);
  assign tx_busy   = tx_full || (tx_state != TX_IDLE);
  assign uart_tx_o = tx_line;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= 16'd0;
      tx_bit_div <= DEFAULT_DIV;
      tx_bit     <= 3'd0;
      tx_shift   <= 8'd0;
      tx_hold    <= 8'd0;
      tx_full    <= 1'b0;
      tx_line    <= 1'b1;
    end else begin
      // Line follows the state one cycle later (registered output).
      tx_line <= (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
      if (wr_data && !tx_full) begin
        tx_hold <= io_dout_i[7:0];
        tx_full <= 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          if (tx_full) begin
            tx_shift   <= tx_hold;
            tx_full    <= 1'b0;
            tx_cnt     <= 16'd0;
            tx_bit_div <= divisor;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt     <= 16'd0;
            tx_bit_div <= divisor;
            tx_bit     <= 3'd0;
            tx_state   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt     <= 16'd0;
            tx_bit_div <= divisor;
            tx_shift   <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_tick) begin
            tx_cnt     <= 16'd0;
            tx_bit_div <= divisor;
            if (tx_full) begin
              tx_shift <= tx_hold;
              tx_full  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Receiver
  rx_state_t   rx_state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] rx_cnt, rx_div, rx_half_m1, rx_full_m1;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_push, rx_stop_bad;

  assign rx_half_m1  = {1'b0, rx_div[15:1]} - 16'd1;
  assign rx_full_m1  = rx_div - 16'd1;
  assign rx_push     = (rx_state == RX_STOP) && (rx_cnt == rx_full_m1);
  assign rx_stop_bad = rx_push && !rx_sync;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= DEFAULT_DIV;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= 16'd0;
            rx_div   <= divisor;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == rx_half_m1) begin
            rx_cnt <= 16'd0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_div   <= divisor;
              rx_bit   <= 3'd0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_full_m1) begin
            rx_cnt   <= 16'd0;
            rx_div   <= divisor;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_push) begin
            rx_cnt   <= 16'd0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // RX buffer
  logic       rx_valid, rx_full, rx_ovf, do_push;
  logic [7:0] rx_head;

  assign rd_pop  = sel && io_rd_i && (idx == 2'd0) && rx_valid;
  assign do_push = rx_push && (!rx_full || rd_pop);
  assign rx_ovf  = rx_push && rx_full && !rd_pop;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;

  assign rx_valid = (fifo_cnt != '0);
  assign rx_full  = (fifo_cnt == FULL_CNT);
  assign rx_head  = fifo_mem[rd_ptr];

  always_ff @(posedge sys_clk_i) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= rx_shift;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (rd_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, rd_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic [7:0] hold_byte;
  logic       hold_valid;
  logic       unused_depth;

  assign unused_depth = ^RX_DEPTH;
  assign rx_valid     = hold_valid;
  assign rx_full      = hold_valid;
  assign rx_head      = hold_byte;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      hold_byte  <= 8'd0;
      hold_valid <= 1'b0;
    end else if (do_push) begin
      hold_byte  <= rx_shift;
      hold_valid <= 1'b1;
    end else if (rd_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  assign rx_irq_o = rx_valid;

  logic ovr, ferr;

  // A new error event in the same cycle as its clear wins.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (wr_stat && io_dout_i[3]) ovr  <= 1'b0;
      if (wr_stat && io_dout_i[4]) ferr <= 1'b0;
      if (rx_ovf)      ovr  <= 1'b1;
      if (rx_stop_bad) ferr <= 1'b1;
    end
  end

  always_comb begin
    io_din_o = 16'h0000;
    if (sel) begin
      case (idx)
        2'd0:    if (rx_valid) io_din_o = {7'b0, 1'b1, rx_head};
        2'd1:    io_din_o = {11'b0, ferr, ovr, tx_full, tx_busy, rx_valid};
        2'd2:    io_din_o = divisor;
        default: io_din_o = 16'h0000;
      endcase
    end
  end

endmodule
